// File: rtl/conv_pkg.sv
// Shared constants and types for the conv stage schedulers.
//   IMG_W / IMG_H      default input frame size in pixels
//   KERNEL             square conv kernel size
//   NUM_CONV_FILTERS   number of parallel conv filters in the datapath
//   DRAIN_CYCLES       MACC/pool pipeline depth flushed after the last pixel
//   sched_state_t      frame scheduler state encoding
package conv_pkg;

  localparam int IMG_W            = 32;
  localparam int IMG_H            = 32;
  localparam int KERNEL           = 5;
  localparam int NUM_CONV_FILTERS = 6;
  localparam int DRAIN_CYCLES     = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;

endpackage

// File: rtl/conv_frame_sched_raster_cnt.sv
// raster_cnt: raster-order col/row position counter.
//   i_clk, i_rst      clock, async active-low reset
//   i_en              advance one pixel (col first, then row)
//   i_clr             synchronous clear to (0,0); wins over i_en
//   o_col, o_row      current position
//   o_col_wrap        col is at IMG_W-1 (next advance starts a new row)
//   o_frame_end       position is the final pixel of the frame
// The counter wraps back to (0,0) after the final pixel.
module raster_cnt #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_clr,
  output logic [$clog2(IMG_W)-1:0] o_col,
  output logic [$clog2(IMG_H)-1:0] o_row,
  output logic                     o_col_wrap,
  output logic                     o_frame_end
);
  import conv_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  assign o_col_wrap  = (col_q == COL_LAST);
  assign o_frame_end = o_col_wrap && (row_q == ROW_LAST);
  assign o_col       = col_q;
  assign o_row       = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_clr) begin
      col_d = '0;
      row_d = '0;
    end else if (i_en) begin
      if (o_col_wrap) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/conv_frame_sched.sv
// conv_frame_sched: pops one frame from the input feature FWFT in raster
// order, flags pixels that complete a KERNEL x KERNEL window for the conv
// MACCs, then drains the MACC pipeline and pulses frame completion.
//   i_clk, i_rst        clock, async active-low reset
//   i_start             begin a frame (honoured in IDLE only)
//   i_abort             synchronous abort back to IDLE, highest priority
//   i_feature_valid     FWFT output holds a pixel
//   o_rd_en             FWFT pop; accept = i_feature_valid && o_rd_en
//   o_macc_en           registered: previous accept completed a window
//   o_out_row/o_out_col output-map coordinate of that window
//   o_last_feature      registered: previous accept was the final pixel
//   o_frame_done        drain finished, downstream results final
//   o_busy              any state other than IDLE
//
//   state | meaning
//   IDLE  | waiting for i_start, counters clear
//   RUN   | popping pixels, tracking row/col
//   DRAIN | final MACC cycle, then DRAIN_CYCLES pipeline flush cycles
//   DONE  | single cycle; o_frame_done follows it
module conv_frame_sched #(
  parameter int IMG_W        = conv_pkg::IMG_W,
  parameter int IMG_H        = conv_pkg::IMG_H,
  parameter int KERNEL       = conv_pkg::KERNEL,
  parameter int DRAIN_CYCLES = conv_pkg::DRAIN_CYCLES
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic                     i_feature_valid,
  output logic                     o_rd_en,
  output logic                     o_macc_en,
  output logic [$clog2(IMG_H)-1:0] o_out_row,
  output logic [$clog2(IMG_W)-1:0] o_out_col,
  output logic                     o_last_feature,
  output logic                     o_frame_done,
  output logic                     o_busy
);
  import conv_pkg::*;

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [RW-1:0] ROW_OFF    = RW'(KERNEL - 1);
  localparam logic [CW-1:0] COL_OFF    = CW'(KERNEL - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  sched_state_t  state_q, state_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          macc_en_q, macc_en_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic          last_feature_q, last_feature_d;
  logic          frame_done_q, frame_done_d;

  logic          accept, cnt_en;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_wrap, frame_end;
  logic          unused_col_wrap;

  assign o_rd_en         = (state_q == RUN);
  assign o_busy          = (state_q != IDLE);
  assign accept          = i_feature_valid && o_rd_en;
  // A pixel popped in the abort cycle leaves the FIFO but is not counted.
  assign cnt_en          = accept && !i_abort;
  assign unused_col_wrap = col_wrap;

  raster_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_raster (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (cnt_en),
    .i_clr       (i_abort),
    .o_col       (col),
    .o_row       (row),
    .o_col_wrap  (col_wrap),
    .o_frame_end (frame_end)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q        <= IDLE;
      drain_cnt_q    <= '0;
      macc_en_q      <= 1'b0;
      out_row_q      <= '0;
      out_col_q      <= '0;
      last_feature_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      macc_en_q      <= macc_en_d;
      out_row_q      <= out_row_d;
      out_col_q      <= out_col_d;
      last_feature_q <= last_feature_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // The first DRAIN cycle carries the final o_macc_en (last_feature_q high);
  // the flush count only starts after it.
  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (i_start) state_d = RUN;
        RUN:     if (cnt_en && frame_end) state_d = DRAIN;
        DRAIN:   if (!last_feature_q && drain_cnt_q == DRAIN_LAST) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    drain_cnt_d    = '0;
    macc_en_d      = 1'b0;
    out_row_d      = out_row_q;
    out_col_d      = out_col_q;
    last_feature_d = 1'b0;
    frame_done_d   = 1'b0;
    if (i_abort) begin
      out_row_d = '0;
      out_col_d = '0;
    end else begin
      if (cnt_en && row >= ROW_OFF && col >= COL_OFF) begin
        macc_en_d = 1'b1;
        out_row_d = row - ROW_OFF;
        out_col_d = col - COL_OFF;
      end
      last_feature_d = cnt_en && frame_end;
      frame_done_d   = (state_q == DONE);
      if (state_q == DRAIN && !last_feature_q && drain_cnt_q != DRAIN_LAST)
        drain_cnt_d = drain_cnt_q + 1'b1;
    end
  end

  assign o_macc_en      = macc_en_q;
  assign o_out_row      = out_row_q;
  assign o_out_col      = out_col_q;
  assign o_last_feature = last_feature_q;
  assign o_frame_done   = frame_done_q;

endmodule

// File: tb/tb_conv_frame_sched.sv
module tb_conv_frame_sched;

  localparam int W = 32;
  localparam int H = 32;
  localparam int K = 5;
  localparam int D = 4;
  localparam int NWIN = (W - K + 1) * (H - K + 1);

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic       i_abort;
  logic       i_feature_valid;
  logic       o_rd_en;
  logic       o_macc_en;
  logic [4:0] o_out_row;
  logic [4:0] o_out_col;
  logic       o_last_feature;
  logic       o_frame_done;
  logic       o_busy;

  conv_frame_sched #(.IMG_W(W), .IMG_H(H), .KERNEL(K), .DRAIN_CYCLES(D)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_start         (i_start),
    .i_abort         (i_abort),
    .i_feature_valid (i_feature_valid),
    .o_rd_en         (o_rd_en),
    .o_macc_en       (o_macc_en),
    .o_out_row       (o_out_row),
    .o_out_col       (o_out_col),
    .o_last_feature  (o_last_feature),
    .o_frame_done    (o_frame_done),
    .o_busy          (o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 fetching, 2 waiting for frame_done.
  int phase, n, drain_left;
  bit e_macc, e_last, e_done;
  int e_r, e_c;
  int cyc;
  int acc_cnt, macc_cnt, done_cnt, first_r, first_c, first_acc, last_cyc, done_cyc;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    phase = 0; n = 0; drain_left = 0;
    e_macc = 0; e_last = 0; e_done = 0;
  endtask

  task automatic clear_stats();
    acc_cnt = 0; macc_cnt = 0; done_cnt = 0;
    first_r = -1; first_c = -1; first_acc = -1; last_cyc = -1; done_cyc = -1;
  endtask

  // Drive one cycle of inputs, advance the model, check at the next negedge.
  task automatic cycle(input bit v, input bit s, input bit a);
    int r, c;
    i_feature_valid = v; i_start = s; i_abort = a;
    if (o_rd_en && v) acc_cnt++;
    e_macc = 0; e_last = 0; e_done = 0;
    if (phase == 1 && v && !a) begin
      r = n / W; c = n % W;
      if (r >= K - 1 && c >= K - 1) begin
        e_macc = 1; e_r = r - (K - 1); e_c = c - (K - 1);
      end
      n++;
      if (n == W * H) begin
        e_last = 1; phase = 2; drain_left = D + 2;
      end
    end else if (a) begin
      phase = 0; n = 0;
    end else if (phase == 0) begin
      if (s) phase = 1;
    end else if (phase == 2) begin
      drain_left--;
      if (drain_left == 0) begin
        e_done = 1; phase = 0; n = 0;
      end
    end
    @(negedge i_clk);
    cyc++;
    chk("rd_en", int'(o_rd_en), int'(phase == 1));
    chk("busy", int'(o_busy), int'(phase != 0));
    chk("macc_en", int'(o_macc_en), int'(e_macc));
    if (e_macc) begin
      chk("out_row", int'(o_out_row), e_r);
      chk("out_col", int'(o_out_col), e_c);
    end
    chk("last_feature", int'(o_last_feature), int'(e_last));
    chk("frame_done", int'(o_frame_done), int'(e_done));
    if (o_macc_en) begin
      macc_cnt++;
      if (macc_cnt == 1) begin
        first_r = int'(o_out_row); first_c = int'(o_out_col); first_acc = acc_cnt;
      end
    end
    if (o_last_feature) last_cyc = cyc;
    if (o_frame_done) begin
      done_cnt++; done_cyc = cyc;
    end
  endtask

  task automatic run_frame(input int stall_pct, input int abort_at, input bit noise);
    bit v, s, a, ended;
    clear_stats();
    cycle(1'b1, 1'b1, 1'b0);
    ended = 0;
    for (int k = 0; k < 20000; k++) begin
      v = ($urandom_range(99) >= stall_pct);
      a = (abort_at >= 0 && phase == 1 && n == abort_at && v);
      s = noise && (phase != 0) && ($urandom_range(9) == 0);
      cycle(v, s, a);
      if (phase == 0) begin
        ended = 1;
        break;
      end
    end
    if (!ended) chk("frame_timeout", 0, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rd_en"}, int'(o_rd_en), 0);
    chk({tag, "_macc_en"}, int'(o_macc_en), 0);
    chk({tag, "_out_row"}, int'(o_out_row), 0);
    chk({tag, "_out_col"}, int'(o_out_col), 0);
    chk({tag, "_last"}, int'(o_last_feature), 0);
    chk({tag, "_done"}, int'(o_frame_done), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
  endtask

  initial begin
    int exp_partial;
    cyc = 0;
    model_reset();
    clear_stats();
    i_rst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_feature_valid = 1'b1;

    // Reset held with valid high
    repeat (5) begin
      @(negedge i_clk);
      check_outputs_zero("reset");
    end
    i_rst = 1'b1;
    repeat (2) cycle(1'b1, 1'b0, 1'b0);

    // Full frame, valid tied high
    run_frame(0, -1, 0);
    chk("full_accepts", acc_cnt, W * H);
    chk("full_macc_count", macc_cnt, NWIN);
    chk("full_first_macc_accept", first_acc, (K - 1) * W + K);
    chk("full_first_row", first_r, 0);
    chk("full_first_col", first_c, 0);
    chk("full_done_count", done_cnt, 1);
    chk("full_last_to_done", done_cyc - last_cyc, D + 2);

    // Random stalls
    run_frame(50, -1, 0);
    chk("stall_accepts", acc_cnt, W * H);
    chk("stall_macc_count", macc_cnt, NWIN);
    chk("stall_done_count", done_cnt, 1);

    // Abort on accept #500
    exp_partial = 0;
    for (int k = 0; k < 499; k++)
      if (k / W >= K - 1 && k % W >= K - 1) exp_partial++;
    run_frame(30, 499, 0);
    chk("abort_accepts", acc_cnt, 500);
    chk("abort_macc_count", macc_cnt, exp_partial);
    chk("abort_done_count", done_cnt, 0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    run_frame(20, -1, 0);
    chk("post_abort_macc_count", macc_cnt, NWIN);
    chk("post_abort_first_row", first_r, 0);
    chk("post_abort_first_col", first_c, 0);

    // Start pulses while busy are ignored
    run_frame(20, -1, 1);
    chk("noise_macc_count", macc_cnt, NWIN);
    chk("noise_done_count", done_cnt, 1);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("start_abort_idle", int'(o_busy), 0);

    // Async reset in the middle of the drain
    clear_stats();
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5000; k++) begin
      if (phase == 2 && drain_left == 3) break;
      cycle(1'b1, 1'b0, 1'b0);
    end
    chk("drain_reached", phase, 2);
    #2 i_rst = 1'b0;
    #1 check_outputs_zero("async_rst");
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    clear_stats();
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    chk("async_rst_no_done", done_cnt, 0);
    run_frame(10, -1, 0);
    chk("after_rst_macc_count", macc_cnt, NWIN);
    chk("after_rst_first_row", first_r, 0);
    chk("after_rst_first_col", first_c, 0);
    chk("after_rst_done_count", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
